sound_event_arbiter: RTL and testbench

- Shares the single audio tone generator among four game-event requesters: player shot, alien hit, bonus-ship hit and player death.
- Each request is a 1-cycle pulse from the game controller. The arbiter latches it as pending and grants the generator by fixed priority.
- Each granted sound plays for a per-sound number of frames, timed on startOfFrame, followed by a silent gap.
- Sits between the game controller's collision/event pulses and the tone generator.

---
 rtl/sound_pkg.sv | 33 +++
 rtl/sound_prio_enc.sv | 18 +
 rtl/sound_event_arbiter.sv | 151 +++++++++++++++
 tb/tb_sound_event_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and helpers for the sound event arbiter: sound ids, FSM states, per-id duration lookup.
// Pure declarations: no latency, no backpressure.
package sound_pkg;

    typedef enum logic [1:0] {
        SND_SHOT  = 2'd0,
        SND_ALIEN = 2'd1,
        SND_BONUS = 2'd2,
        SND_DEATH = 2'd3
    } sound_id_t;

    typedef enum logic [1:0] {
        sIdle = 2'd0,
        sPlay = 2'd1,
        sGap  = 2'd2
    } state_t;

    function automatic logic [5:0] dur_of(
        input sound_id_t  id,
        input logic [5:0] d_shot,
        input logic [5:0] d_alien,
        input logic [5:0] d_bonus,
        input logic [5:0] d_death
    );
        case (id)
            SND_SHOT:  return d_shot;
            SND_ALIEN: return d_alien;
            SND_BONUS: return d_bonus;
            default:   return d_death;
        endcase
    endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Fixed-priority encoder over pending sounds (death > bonus > alien > shot); combinational, zero latency.
// No backpressure: output follows input in the same cycle.
module sound_prio_enc (
    input  logic [3:0] i_pending,
    output logic       o_any,
    output logic [1:0] o_top_id
);

    assign o_any = |i_pending;

    always_comb begin
        o_top_id = 2'd0;
        if (i_pending[3])      o_top_id = 2'd3;
        else if (i_pending[2]) o_top_id = 2'd2;
        else if (i_pending[1]) o_top_id = 2'd1;
    end

endmodule

// File: rtl/sound_event_arbiter.sv
// Arbitrates four event pulses onto one tone generator; request-to-tone_en latency 2 cycles; SOUND_PREEMPT_EN lets higher priority cut in.
// No backpressure: requests are latched as pending and served one at a time, mute flushes everything.
module sound_event_arbiter
    import sound_pkg::*;
#(
    parameter int DUR_SHOT   = 6,
    parameter int DUR_ALIEN  = 10,
    parameter int DUR_BONUS  = 30,
    parameter int DUR_DEATH  = 60,
    parameter int GAP_FRAMES = 1
)(
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       mute,
    input  logic       req_shot,
    input  logic       req_alien,
    input  logic       req_bonus,
    input  logic       req_death,
    output logic       tone_en,
    output logic [1:0] sound_id,
    output logic [3:0] tone_step,
    output logic       sound_start,
    output logic       busy
);

    localparam logic [5:0] L_DUR_SHOT  = 6'(DUR_SHOT);
    localparam logic [5:0] L_DUR_ALIEN = 6'(DUR_ALIEN);
    localparam logic [5:0] L_DUR_BONUS = 6'(DUR_BONUS);
    localparam logic [5:0] L_DUR_DEATH = 6'(DUR_DEATH);
    localparam logic [2:0] L_GAP       = 3'(GAP_FRAMES);

    state_t     r_state;
    sound_id_t  r_sound_id;
    logic [3:0] r_pending;
    logic [5:0] r_frame_cnt;
    logic [2:0] r_gap_cnt;
    logic [3:0] r_tone_step;
    logic       r_tone_en;
    logic       r_sound_start;

    logic [3:0] w_req;
    logic [3:0] w_cur_mask;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic       w_any;
    logic [1:0] w_top_id;
    logic       w_retrig;
    logic       w_preempt;
    logic       w_grant;
    logic [5:0] w_new_dur;
    logic [5:0] w_cur_dur;

    sound_prio_enc u_prio (
        .i_pending (r_pending),
        .o_any     (w_any),
        .o_top_id  (w_top_id)
    );

    assign w_req      = {req_death, req_bonus, req_alien, req_shot};
    assign w_cur_mask = 4'b0001 << r_sound_id;
    assign w_retrig   = !mute && (r_state == sPlay) && |(w_req & w_cur_mask);

`ifdef SOUND_PREEMPT_EN
    assign w_preempt  = (r_state == sPlay) && w_any && (w_top_id > 2'(r_sound_id));
`else
    assign w_preempt  = 1'b0;
`endif

    assign w_grant    = !mute && w_any && ((r_state == sIdle) || w_preempt);
    // A request for the sound already playing is a retrigger, not a new queue entry.
    assign w_set      = mute ? 4'b0000 : ((r_state == sPlay) ? (w_req & ~w_cur_mask) : w_req);
    assign w_clr      = w_grant ? (4'b0001 << w_top_id) : 4'b0000;
    assign w_new_dur  = dur_of(sound_id_t'(w_top_id), L_DUR_SHOT, L_DUR_ALIEN, L_DUR_BONUS, L_DUR_DEATH);
    assign w_cur_dur  = dur_of(r_sound_id, L_DUR_SHOT, L_DUR_ALIEN, L_DUR_BONUS, L_DUR_DEATH);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= sIdle;
            r_sound_id    <= SND_SHOT;
            r_pending     <= 4'b0000;
            r_frame_cnt   <= 6'd0;
            r_gap_cnt     <= 3'd0;
            r_tone_step   <= 4'd0;
            r_tone_en     <= 1'b0;
            r_sound_start <= 1'b0;
        end else begin
            r_sound_start <= 1'b0;
            if (mute) begin
                r_state     <= sIdle;
                r_pending   <= 4'b0000;
                r_frame_cnt <= 6'd0;
                r_gap_cnt   <= 3'd0;
                r_tone_step <= 4'd0;
                r_tone_en   <= 1'b0;
            end else begin
                // Set wins over clear so a same-cycle re-request replays later.
                r_pending <= (r_pending & ~w_clr) | w_set;
                if (w_grant) begin
                    r_state       <= sPlay;
                    r_sound_id    <= sound_id_t'(w_top_id);
                    r_frame_cnt   <= w_new_dur;
                    r_gap_cnt     <= 3'd0;
                    r_tone_step   <= 4'd0;
                    r_tone_en     <= 1'b1;
                    r_sound_start <= 1'b1;
                end else begin
                    case (r_state)
                        sPlay: begin
                            if (w_retrig) begin
                                r_frame_cnt <= w_cur_dur;
                                r_tone_step <= 4'd0;
                            end else if (startOfFrame) begin
                                r_frame_cnt <= r_frame_cnt - 6'd1;
                                if (r_tone_step != 4'hF)
                                    r_tone_step <= r_tone_step + 4'd1;
                                if (r_frame_cnt == 6'd1) begin
                                    r_tone_en <= 1'b0;
                                    if (L_GAP == 3'd0) begin
                                        r_state <= sIdle;
                                    end else begin
                                        r_state   <= sGap;
                                        r_gap_cnt <= L_GAP;
                                    end
                                end
                            end
                        end
                        sGap: begin
                            if (startOfFrame) begin
                                if (r_gap_cnt <= 3'd1) begin
                                    r_gap_cnt <= 3'd0;
                                    r_state   <= sIdle;
                                end else begin
                                    r_gap_cnt <= r_gap_cnt - 3'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tone_en     = r_tone_en;
    assign sound_id    = r_sound_id;
    assign tone_step   = r_tone_step;
    assign sound_start = r_sound_start;
    assign busy        = (r_state != sIdle);

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Scoreboard bench for sound_event_arbiter: expected grants queued at request time, checked on sound_start/tone_en edges.
// Covers reset, single grant, priority order, retrigger, mute flush, preemption and mid-play reset.
`timescale 1ns/1ps
module tb_sound_event_arbiter;

    logic       clk          = 1'b0;
    logic       resetN       = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       mute         = 1'b0;
    logic       req_shot     = 1'b0;
    logic       req_alien    = 1'b0;
    logic       req_bonus    = 1'b0;
    logic       req_death    = 1'b0;
    logic       tone_en;
    logic [1:0] sound_id;
    logic [3:0] tone_step;
    logic       sound_start;
    logic       busy;

    sound_event_arbiter dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .mute         (mute),
        .req_shot     (req_shot),
        .req_alien    (req_alien),
        .req_bonus    (req_bonus),
        .req_death    (req_death),
        .tone_en      (tone_en),
        .sound_id     (sound_id),
        .tone_step    (tone_step),
        .sound_start  (sound_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int frames;     // sof pulses with tone_en high; -1 = not checked
        int start_cyc;  // cycle of sound_start; -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic cur_vld    = 1'b0;
    int   cur_frames = 0;
    int   fall_cyc   = 0;
    logic prev_en    = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   period     = 100;
    int   sof_ctr    = 0;

    task automatic chk(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        sof_ctr      = (sof_ctr + 1 >= period) ? 0 : sof_ctr + 1;
        startOfFrame = (sof_ctr == 0);
    end

    // Monitor: pops one expectation per sound_start and checks the played length when tone_en drops.
    initial forever begin
        @(negedge clk);
        if (!resetN) begin
            cur_vld = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (sound_start) begin
                if (cur_vld && cur.frames >= 0)
                    chk("frames_before_preempt", cur_frames, cur.frames);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", int'(sound_start), 0);
                    cur_vld = 1'b0;
                end else begin
                    cur        = exp_q.pop_front();
                    cur_vld    = 1'b1;
                    cur_frames = 0;
                    chk("start_sound_id", int'(sound_id), cur.id);
                    chk("start_tone_step", int'(tone_step), 0);
                    chk("start_tone_en", int'(tone_en), 1);
                    if (cur.start_cyc >= 0)
                        chk("grant_latency", cyc, cur.start_cyc);
                end
            end
            if (cur_vld && startOfFrame && tone_en)
                cur_frames++;
            if (prev_en && !tone_en && cur_vld) begin
                fall_cyc = cyc;
                if (cur.frames >= 0) begin
                    chk("frames_played", cur_frames, cur.frames);
                    chk("gap_busy", int'(busy), 1);
                    chk("id_hold_in_gap", int'(sound_id), cur.id);
                end
                cur_vld = 1'b0;
            end
            prev_en = tone_en;
        end
    end

    task automatic pulse(input logic [3:0] m, output int rc);
        @(posedge clk);
        #1;
        rc = cyc;
        {req_death, req_bonus, req_alien, req_shot} = m;
        @(posedge clk);
        #1;
        {req_death, req_bonus, req_alien, req_shot} = 4'b0000;
    endtask

    task automatic push(input int id, input int frames, input int start_cyc);
        exp_t e;
        e.id        = id;
        e.frames    = frames;
        e.start_cyc = start_cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_step(input int tgt, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tone_en && int'(tone_step) == tgt) ok = 1'b1;
        end
        if (!ok) chk("timeout_tone_step", int'(tone_step), tgt);
    endtask

    task automatic wait_quiet(input int budget);
        bit ok = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !cur_vld && !busy) ok = 1'b1;
        end
        if (!ok) chk("timeout_quiet", exp_q.size() + int'(cur_vld) + int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int rd;

        repeat (3) @(negedge clk);
        chk("reset_tone_en", int'(tone_en), 0);
        chk("reset_sound_id", int'(sound_id), 0);
        chk("reset_tone_step", int'(tone_step), 0);
        chk("reset_sound_start", int'(sound_start), 0);
        chk("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (5) @(posedge clk);

        // Single alien hit, 100-cycle frames: 10 frames then one gap frame.
        period = 100;
        pulse(4'b0010, rc);
        push(1, 10, rc + 2);
        wait_quiet(3000);
        chk("gap_cycles", cyc - fall_cyc, period);
        chk("idle_tone_en", int'(tone_en), 0);
        chk("idle_id_hold", int'(sound_id), 1);

        // Shot and death together: death first, then shot.
        period = 20;
        pulse(4'b1001, rc);
        push(3, 60, rc + 2);
        push(0, 6, -1);
        wait_quiet(3000);

        // Retrigger a shot during its fourth frame.
        pulse(4'b0001, rc);
        push(0, 9, rc + 2);
        wait_step(3, 200);
        pulse(4'b0001, rd);
        @(negedge clk);
        chk("retrig_tone_step", int'(tone_step), 0);
        chk("retrig_tone_en", int'(tone_en), 1);
        wait_quiet(3000);

        // Mute during bonus frame 5 with an alien pending; nothing may play afterwards.
        pulse(4'b0100, rc);
        push(2, -1, rc + 2);
        wait_step(4, 200);
        pulse(4'b0010, rd);
        @(posedge clk);
        #1;
        mute = 1'b1;
        @(posedge clk);
        #1;
        chk("mute_tone_en", int'(tone_en), 0);
        chk("mute_busy", int'(busy), 0);
        chk("mute_tone_step", int'(tone_step), 0);
        pulse(4'b0010, rd);
        repeat (4) @(posedge clk);
        #1;
        mute = 1'b0;
        repeat (3 * period) @(negedge clk);
        chk("post_mute_busy", int'(busy), 0);
        chk("post_mute_tone_en", int'(tone_en), 0);
        wait_quiet(100);

        // Death requested during shot frame 2.
        pulse(4'b0001, rc);
`ifdef SOUND_PREEMPT_EN
        push(0, -1, rc + 2);
`else
        push(0, 6, rc + 2);
`endif
        wait_step(1, 200);
        pulse(4'b1000, rd);
`ifdef SOUND_PREEMPT_EN
        push(3, 60, rd + 2);
`else
        push(3, 60, -1);
`endif
        wait_quiet(3000);

        // Asynchronous reset in the middle of an alien hit.
        pulse(4'b0010, rc);
        push(1, -1, rc + 2);
        wait_step(2, 200);
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_tone_en", int'(tone_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sound_id", int'(sound_id), 0);
        chk("arst_tone_step", int'(tone_step), 0);
        chk("arst_sound_start", int'(sound_start), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (3 * period) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_tone_en", int'(tone_en), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
